// File: rtl/amba_axi4_protocol_checker_pkg.sv
`default_nettype none
// ============================================================================
// Package  : amba_axi4_protocol_checker_pkg
// Purpose  : Shared types for the AXI4-Lite monitor blocks (transaction
//            tracker error map and parameter bundle).
// Revision : 1.0 - initial release
// ============================================================================
package amba_axi4_protocol_checker_pkg;

  // Width of the tracker sticky error vector.
  localparam int TRK_ERR_W = 8;

  // Bit positions inside the tracker ERR vector.
  typedef enum logic [2:0] {
    TRK_B_ORPHAN    = 3'd0,
    TRK_R_ORPHAN    = 3'd1,
    TRK_WR_ADDR_OVF = 3'd2,
    TRK_WR_DATA_OVF = 3'd3,
    TRK_RD_OVF      = 3'd4,
    TRK_B_TIMEOUT   = 3'd5,
    TRK_R_TIMEOUT   = 3'd6,
    TRK_RSVD        = 3'd7
  } axi4lite_trk_err_e;

  // Parameter bundle describing one tracker instance.
  typedef struct packed {
    int unsigned max_outstanding;
    int unsigned maxwait;
    int unsigned stat_width;
    logic        enable_watchdog;
  } axi4lite_trk_params_t;

endpackage
`default_nettype wire

// File: rtl/amba_axi4lite_wait_counter.sv
`default_nettype none
// ============================================================================
// Module   : amba_axi4lite_wait_counter
// Purpose  : Response watchdog. Counts cycles a response has been pending,
//            saturating at MAXWAIT; fire marks the cycle the count reaches
//            (or sits at) MAXWAIT.
// Revision : 1.0 - initial release
// ============================================================================
module amba_axi4lite_wait_counter #(
  parameter int MAXWAIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pending,
  input  logic done,
  input  logic clear,
  output logic fire
);

  localparam int                WAIT_W  = $clog2(MAXWAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MX = WAIT_W'(MAXWAIT);

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;

  // Next wait count: restart when idle, answered or cleared, else saturate up.
  always_comb begin
    cnt_d = cnt_q;
    if (clear || !pending || done) begin
      cnt_d = '0;
    end else if (cnt_q != WAIT_MX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Firing coincides with the edge that brings the count to MAXWAIT, so a
  // response seen while the count is MAXWAIT-1 is still in time.
  assign fire = (cnt_d == WAIT_MX);

  // Wait count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/amba_axi4lite_txn_tracker.sv
`default_nettype none
// ============================================================================
// Module   : amba_axi4lite_txn_tracker
// Purpose  : Passive AXI4-Lite transaction tracker: outstanding counters,
//            response watchdogs, sticky protocol errors and saturating
//            completion / error-response statistics.
// Revision : 1.0 - initial release
// ============================================================================
module amba_axi4lite_txn_tracker
  import amba_axi4_protocol_checker_pkg::*;
#(
  parameter  int MAX_OUTSTANDING = 8,
  parameter  int MAXWAIT         = 16,
  parameter  int STAT_WIDTH      = 32,
  parameter  int ENABLE_WATCHDOG = 1,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  AWVALID,
  input  logic                  AWREADY,
  input  logic                  WVALID,
  input  logic                  WREADY,
  input  logic                  BVALID,
  input  logic                  BREADY,
  input  logic [1:0]            BRESP,
  input  logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic                  RVALID,
  input  logic                  RREADY,
  input  logic [1:0]            RRESP,
  input  logic                  ERR_CLEAR,
  output logic [CNT_W-1:0]      WR_ADDR_OUT,
  output logic [CNT_W-1:0]      WR_DATA_OUT,
  output logic [CNT_W-1:0]      RD_OUT,
  output logic [TRK_ERR_W-1:0]  ERR,
  output logic                  ERR_ANY,
  output logic [STAT_WIDTH-1:0] WR_DONE,
  output logic [STAT_WIDTH-1:0] RD_DONE,
  output logic [STAT_WIDTH-1:0] RESP_ERR
);

  localparam axi4lite_trk_params_t P = '{
    max_outstanding: MAX_OUTSTANDING,
    maxwait:         MAXWAIT,
    stat_width:      STAT_WIDTH,
    enable_watchdog: (ENABLE_WATCHDOG != 0)
  };
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(P.max_outstanding);

  // Bounded up/down step: simultaneous inc+dec cancels, limits hold.
  function automatic logic [CNT_W-1:0] f_bump(input logic [CNT_W-1:0] cur,
                                              input logic inc, input logic dec);
    logic [CNT_W-1:0] nxt;
    nxt = cur;
    if (inc && !dec && (cur != MAX_CNT)) nxt = cur + 1'b1;
    else if (dec && !inc && (cur != '0)) nxt = cur - 1'b1;
    return nxt;
  endfunction

  // Saturating add of 0..2 to a statistics counter.
  function automatic logic [STAT_WIDTH-1:0] f_sat_add(input logic [STAT_WIDTH-1:0] cur,
                                                      input logic [1:0] inc);
    logic [STAT_WIDTH:0] sum;
    sum = {1'b0, cur} + {{(STAT_WIDTH-1){1'b0}}, inc};
    return sum[STAT_WIDTH] ? {STAT_WIDTH{1'b1}} : sum[STAT_WIDTH-1:0];
  endfunction

  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic w_b_pend, w_r_pend, w_b_fire, w_r_fire;
  logic [TRK_ERR_W-1:0] w_err_new;
  logic [1:0]           w_resp_inc;
  logic                 w_unused_resp;

  logic [CNT_W-1:0]      wa_q, wa_d, wd_q, wd_d, rd_q, rd_d;
  logic [TRK_ERR_W-1:0]  err_q, err_d;
  logic                  err_any_q;
  logic [STAT_WIDTH-1:0] wr_done_q, wr_done_d, rd_done_q, rd_done_d, resp_err_q, resp_err_d;

  assign w_aw_hs = AWVALID & AWREADY;
  assign w_w_hs  = WVALID  & WREADY;
  assign w_b_hs  = BVALID  & BREADY;
  assign w_ar_hs = ARVALID & ARREADY;
  assign w_r_hs  = RVALID  & RREADY;

  // Only the error class bit of each response matters for statistics.
  assign w_unused_resp = BRESP[0] ^ RRESP[0];

  assign w_b_pend = (wa_q != '0) && (wd_q != '0);
  assign w_r_pend = (rd_q != '0);

  generate
    if (P.enable_watchdog) begin : g_wdog
      amba_axi4lite_wait_counter #(.MAXWAIT(MAXWAIT)) u_b_wait (
        .clk(ACLK), .rst(ARESET), .pending(w_b_pend), .done(w_b_hs),
        .clear(ERR_CLEAR), .fire(w_b_fire)
      );
      amba_axi4lite_wait_counter #(.MAXWAIT(MAXWAIT)) u_r_wait (
        .clk(ACLK), .rst(ARESET), .pending(w_r_pend), .done(w_r_hs),
        .clear(ERR_CLEAR), .fire(w_r_fire)
      );
    end else begin : g_no_wdog
      logic w_unused_pend;
      assign w_unused_pend = w_b_pend ^ w_r_pend;
      assign w_b_fire      = 1'b0;
      assign w_r_fire      = 1'b0;
    end
  endgenerate

  // Next-state for outstanding counters, sticky errors and statistics.
  always_comb begin
    wa_d = f_bump(wa_q, w_aw_hs, w_b_hs);
    wd_d = f_bump(wd_q, w_w_hs,  w_b_hs);
    rd_d = f_bump(rd_q, w_ar_hs, w_r_hs);

    w_err_new                  = '0;
    w_err_new[TRK_B_ORPHAN]    = w_b_hs && ((wa_q == '0) || (wd_q == '0));
    w_err_new[TRK_R_ORPHAN]    = w_r_hs && (rd_q == '0);
    w_err_new[TRK_WR_ADDR_OVF] = w_aw_hs && !w_b_hs && (wa_q == MAX_CNT);
    w_err_new[TRK_WR_DATA_OVF] = w_w_hs  && !w_b_hs && (wd_q == MAX_CNT);
    w_err_new[TRK_RD_OVF]      = w_ar_hs && !w_r_hs && (rd_q == MAX_CNT);
    w_err_new[TRK_B_TIMEOUT]   = w_b_fire;
    w_err_new[TRK_R_TIMEOUT]   = w_r_fire;

    w_resp_inc = {1'b0, w_b_hs & BRESP[1]} + {1'b0, w_r_hs & RRESP[1]};

    if (ERR_CLEAR) begin
      err_d      = '0;
      wr_done_d  = '0;
      rd_done_d  = '0;
      resp_err_d = '0;
    end else begin
      err_d      = err_q | w_err_new;
      wr_done_d  = f_sat_add(wr_done_q,  {1'b0, w_b_hs});
      rd_done_d  = f_sat_add(rd_done_q,  {1'b0, w_r_hs});
      resp_err_d = f_sat_add(resp_err_q, w_resp_inc);
    end
  end

  // State registers; ERR_ANY trails ERR by one cycle.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wa_q       <= '0;
      wd_q       <= '0;
      rd_q       <= '0;
      err_q      <= '0;
      err_any_q  <= 1'b0;
      wr_done_q  <= '0;
      rd_done_q  <= '0;
      resp_err_q <= '0;
    end else begin
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      rd_q       <= rd_d;
      err_q      <= err_d;
      err_any_q  <= |err_q;
      wr_done_q  <= wr_done_d;
      rd_done_q  <= rd_done_d;
      resp_err_q <= resp_err_d;
    end
  end

  assign WR_ADDR_OUT = wa_q;
  assign WR_DATA_OUT = wd_q;
  assign RD_OUT      = rd_q;
  assign ERR         = err_q;
  assign ERR_ANY     = err_any_q;
  assign WR_DONE     = wr_done_q;
  assign RD_DONE     = rd_done_q;
  assign RESP_ERR    = resp_err_q;

endmodule
`default_nettype wire
